// File: rtl/ycbcr_pseudocolor_pipe_if.sv
// Pixel stream bundle for the pseudo-colour mapper:
// intensity samples in, registered YCbCr triples out.
interface ycbcr_pseudocolor_pipe_if #(
   parameter int DW = 10
);
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [DW-1:0] in_blue;
   logic          in_sof;
   logic          in_eof;
   logic          out_valid;
   logic [DW-1:0] out_y;
   logic [DW-1:0] out_cb;
   logic [DW-1:0] out_cr;

   modport master (
      output in_valid, in_data, in_blue,
      output in_sof, in_eof,
      input  out_valid, out_y, out_cb, out_cr
   );

   modport slave (
      input  in_valid, in_data, in_blue,
      input  in_sof, in_eof,
      output out_valid, out_y, out_cb, out_cr
   );
endinterface

// File: rtl/ycbcr_pseudocolor_pipe.sv
// Two-stage intensity -> YCbCr pseudo-colour mapper with
// frame-synchronous config shadowing and per-frame band stats.
module ycbcr_pseudocolor_pipe #(
   parameter int DW         = 10,
   parameter int THR_LO_DEF = 240,
   parameter int THR_HI_DEF = 767,
   parameter int CR_SAT     = 255,
   parameter int CNT_W      = 22
) (
   input  logic                   clk,
   input  logic                   reset,
   ycbcr_pseudocolor_pipe_if.slave px,
   input  logic [1:0]             cfg_mode,
   input  logic [DW-1:0]          cfg_thr_lo,
   input  logic [DW-1:0]          cfg_thr_hi,
   output logic [CNT_W-1:0]       stat_low,
   output logic [CNT_W-1:0]       stat_mid,
   output logic                   stat_valid
);

   typedef enum logic [1:0] {
      MODE_GRAY   = 2'd0,
      MODE_TWO    = 2'd1,
      MODE_THREE  = 2'd2,
      MODE_FREEZE = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      BAND_LO  = 2'd0,
      BAND_MID = 2'd1,
      BAND_HI  = 2'd2
   } band_e;

   localparam logic [DW-1:0] C_MID =
      {1'b1, {(DW-1){1'b0}}};
   localparam logic [DW-1:0] CB_BLUE =
      C_MID + DW'(5);
   localparam logic [DW-1:0] CB_RED =
      {2'b11, {(DW-2){1'b0}}};
   localparam logic [DW-1:0] CR_YEL = DW'(CR_SAT);
   localparam logic [DW-1:0] LO_DEF = DW'(THR_LO_DEF);
   localparam logic [DW-1:0] HI_DEF = DW'(THR_HI_DEF);

   mode_e            act_mode_q, act_mode_d;
   logic [DW-1:0]    act_lo_q, act_lo_d;
   logic [DW-1:0]    act_hi_q, act_hi_d;
   logic [CNT_W-1:0] cnt_low_q, cnt_low_d;
   logic [CNT_W-1:0] cnt_mid_q, cnt_mid_d;
   logic [CNT_W-1:0] base_low, base_mid;
   logic             load;
   band_e            band;

   logic             s1_valid_q, s1_valid_d;
   logic             s1_eof_q, s1_eof_d;
   logic [DW-1:0]    s1_data_q, s1_data_d;
   logic [DW-1:0]    s1_blue_q, s1_blue_d;
   band_e            s1_band_q, s1_band_d;
   mode_e            s1_mode_q, s1_mode_d;

   logic             out_valid_q, out_valid_d;
   logic [DW-1:0]    out_y_q, out_y_d;
   logic [DW-1:0]    out_cb_q, out_cb_d;
   logic [DW-1:0]    out_cr_q, out_cr_d;
   logic             stat_valid_q, stat_valid_d;
   logic [CNT_W-1:0] stat_low_q, stat_low_d;
   logic [CNT_W-1:0] stat_mid_q, stat_mid_d;

   logic [DW:0]      cr_sum;
   logic [DW-1:0]    cr_blue, y_blue, y_red;
   logic             sel_frz, sel_gray;
   logic             sel_blue, sel_red;

   // sof pixel already sees the freshly loaded config
   always_comb begin
      load       = px.in_valid & px.in_sof;
      act_mode_d = act_mode_q;
      act_lo_d   = act_lo_q;
      act_hi_d   = act_hi_q;
      if (load) begin
         act_mode_d = mode_e'(cfg_mode);
         act_lo_d   = cfg_thr_lo;
         act_hi_d   = cfg_thr_hi;
      end
      if (px.in_data < act_lo_d)
         band = BAND_LO;
      else if (px.in_data <= act_hi_d)
         band = BAND_MID;
      else
         band = BAND_HI;
   end

   always_comb begin
      base_low  = load ? '0 : cnt_low_q;
      base_mid  = load ? '0 : cnt_mid_q;
      cnt_low_d = cnt_low_q;
      cnt_mid_d = cnt_mid_q;
      if (px.in_valid) begin
         cnt_low_d = base_low;
         cnt_mid_d = base_mid;
         if (band == BAND_LO && !(&base_low))
            cnt_low_d = base_low + CNT_W'(1);
         if (band == BAND_MID && !(&base_mid))
            cnt_mid_d = base_mid + CNT_W'(1);
      end
   end

   always_comb begin
      s1_valid_d = px.in_valid;
      s1_eof_d   = px.in_valid & px.in_eof;
      s1_data_d  = px.in_data;
      s1_blue_d  = px.in_blue;
      s1_band_d  = band;
      s1_mode_d  = act_mode_d;
   end

   always_comb begin
      cr_sum   = {1'b0, C_MID} + {1'b0, s1_data_q};
      cr_blue  = cr_sum[DW] ? '1 : cr_sum[DW-1:0];
      y_blue   = {s1_data_q[DW-2:0], 1'b1};
      y_red    = {1'b0, s1_data_q[DW-3:0], 1'b0};
      sel_frz  = s1_mode_q == MODE_FREEZE;
      sel_gray = s1_mode_q == MODE_GRAY;
      sel_blue = (s1_mode_q == MODE_TWO ||
                  s1_mode_q == MODE_THREE) &&
                 s1_band_q == BAND_LO;
      sel_red  = s1_mode_q == MODE_THREE &&
                 s1_band_q == BAND_MID;
   end

   // outputs hold on idle cycles and in freeze mode
   always_comb begin
      out_valid_d = s1_valid_q;
      out_y_d     = out_y_q;
      out_cb_d    = out_cb_q;
      out_cr_d    = out_cr_q;
      if (s1_valid_q) begin
         unique case (1'b1)
            sel_frz: begin
               out_y_d = out_y_q;
            end
            sel_gray: begin
               out_y_d  = s1_data_q;
               out_cb_d = C_MID;
               out_cr_d = C_MID;
            end
            sel_blue: begin
               out_y_d  = y_blue;
               out_cb_d = CB_BLUE;
               out_cr_d = cr_blue;
            end
            sel_red: begin
               out_y_d  = y_red;
               out_cb_d = CB_RED;
               out_cr_d = C_MID;
            end
            default: begin
               out_y_d  = s1_data_q;
               out_cb_d = s1_blue_q;
               out_cr_d = CR_YEL;
            end
         endcase
      end
   end

   // cnt_*_q already includes the eof pixel one edge earlier
   always_comb begin
      stat_valid_d = s1_valid_q & s1_eof_q;
      stat_low_d   = stat_low_q;
      stat_mid_d   = stat_mid_q;
      if (stat_valid_d) begin
         stat_low_d = cnt_low_q;
         stat_mid_d = cnt_mid_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         act_mode_q   <= MODE_TWO;
         act_lo_q     <= LO_DEF;
         act_hi_q     <= HI_DEF;
         cnt_low_q    <= '0;
         cnt_mid_q    <= '0;
         s1_valid_q   <= 1'b0;
         s1_eof_q     <= 1'b0;
         s1_data_q    <= '0;
         s1_blue_q    <= '0;
         s1_band_q    <= BAND_LO;
         s1_mode_q    <= MODE_TWO;
         out_valid_q  <= 1'b0;
         out_y_q      <= '0;
         out_cb_q     <= C_MID;
         out_cr_q     <= C_MID;
         stat_valid_q <= 1'b0;
         stat_low_q   <= '0;
         stat_mid_q   <= '0;
      end else begin
         act_mode_q   <= act_mode_d;
         act_lo_q     <= act_lo_d;
         act_hi_q     <= act_hi_d;
         cnt_low_q    <= cnt_low_d;
         cnt_mid_q    <= cnt_mid_d;
         s1_valid_q   <= s1_valid_d;
         s1_eof_q     <= s1_eof_d;
         s1_data_q    <= s1_data_d;
         s1_blue_q    <= s1_blue_d;
         s1_band_q    <= s1_band_d;
         s1_mode_q    <= s1_mode_d;
         out_valid_q  <= out_valid_d;
         out_y_q      <= out_y_d;
         out_cb_q     <= out_cb_d;
         out_cr_q     <= out_cr_d;
         stat_valid_q <= stat_valid_d;
         stat_low_q   <= stat_low_d;
         stat_mid_q   <= stat_mid_d;
      end
   end

   assign px.out_valid = out_valid_q;
   assign px.out_y     = out_y_q;
   assign px.out_cb    = out_cb_q;
   assign px.out_cr    = out_cr_q;
   assign stat_valid   = stat_valid_q;
   assign stat_low     = stat_low_q;
   assign stat_mid     = stat_mid_q;

endmodule

// File: tb/tb_ycbcr_pseudocolor_pipe.sv
// Directed bench for ycbcr_pseudocolor_pipe: mapping table,
// shadowing, band statistics and asynchronous reset.
module tb_ycbcr_pseudocolor_pipe;

   localparam int DW    = 10;
   localparam int CNT_W = 22;

   typedef struct {
      logic          sof;
      logic          eof;
      logic [1:0]    mode;
      logic [DW-1:0] lo;
      logic [DW-1:0] hi;
      logic [DW-1:0] data;
      logic [DW-1:0] blue;
      logic [DW-1:0] ey;
      logic [DW-1:0] ecb;
      logic [DW-1:0] ecr;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [1:0]       cfg_mode;
   logic [DW-1:0]    cfg_thr_lo;
   logic [DW-1:0]    cfg_thr_hi;
   logic [CNT_W-1:0] stat_low;
   logic [CNT_W-1:0] stat_mid;
   logic             stat_valid;

   int checks = 0;
   int errors = 0;
   int pulses;
   int pcyc;
   vec_t tv[$];

   ycbcr_pseudocolor_pipe_if #(.DW(DW)) px ();

   ycbcr_pseudocolor_pipe #(
      .DW(DW), .THR_LO_DEF(240), .THR_HI_DEF(767),
      .CR_SAT(255), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .px(px),
      .cfg_mode(cfg_mode),
      .cfg_thr_lo(cfg_thr_lo),
      .cfg_thr_hi(cfg_thr_hi),
      .stat_low(stat_low),
      .stat_mid(stat_mid),
      .stat_valid(stat_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic sof,
                        input logic eof, input logic [1:0] m,
                        input logic [DW-1:0] lo,
                        input logic [DW-1:0] hi,
                        input logic [DW-1:0] d,
                        input logic [DW-1:0] b);
      px.in_valid = v;
      px.in_sof   = sof;
      px.in_eof   = eof;
      px.in_data  = d;
      px.in_blue  = b;
      cfg_mode    = m;
      cfg_thr_lo  = lo;
      cfg_thr_hi  = hi;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic sof, input logic eof,
                      input logic [1:0] m,
                      input logic [DW-1:0] lo,
                      input logic [DW-1:0] hi,
                      input logic [DW-1:0] d,
                      input logic [DW-1:0] b,
                      input logic [DW-1:0] y,
                      input logic [DW-1:0] cb,
                      input logic [DW-1:0] cr);
      vec_t v;
      v.sof = sof; v.eof = eof; v.mode = m;
      v.lo = lo; v.hi = hi; v.data = d; v.blue = b;
      v.ey = y; v.ecb = cb; v.ecr = cr;
      tv.push_back(v);
   endtask

   task automatic check_out(input string tag,
                            input logic [DW-1:0] y,
                            input logic [DW-1:0] cb,
                            input logic [DW-1:0] cr);
      check({tag, ".valid"}, 32'(px.out_valid), 1);
      check({tag, ".y"},  32'(px.out_y),  32'(y));
      check({tag, ".cb"}, 32'(px.out_cb), 32'(cb));
      check({tag, ".cr"}, 32'(px.out_cr), 32'(cr));
   endtask

   initial begin
      // mode 2, 240/767: blue, red, yellow
      add(1, 0, 2, 240, 767, 100, 'h155,
          'h0C9, 'h205, 'h264);
      add(0, 0, 0, 0, 0, 500, 'h155,
          'h1E8, 'h300, 'h200);
      add(0, 1, 0, 0, 0, 900, 'h155,
          'h384, 'h155, 'h0FF);
      add(1, 0, 1, 240, 767, 500, 'h0AA,
          'h1F4, 'h0AA, 'h0FF);
      add(1, 0, 0, 240, 767, 500, 'h0AA,
          'h1F4, 'h200, 'h200);
      add(0, 0, 2, 240, 767, 100, 'h0AA,
          'h064, 'h200, 'h200);
      add(1, 0, 2, 1023, 1023, 1000, 'h0AA,
          'h3D1, 'h205, 'h3FF);
      add(1, 0, 2, 600, 100, 700, 'h033,
          'h2BC, 'h033, 'h0FF);
      add(0, 0, 2, 0, 0, 300, 'h033,
          'h259, 'h205, 'h32C);
      add(1, 0, 2, 240, 767, 240, 'h111,
          'h1E0, 'h300, 'h200);
      add(0, 0, 2, 0, 0, 767, 'h111,
          'h1FE, 'h300, 'h200);
      add(0, 0, 2, 0, 0, 768, 'h111,
          'h300, 'h111, 'h0FF);
      add(0, 0, 2, 0, 0, 239, 'h111,
          'h1DF, 'h205, 'h2EF);
      add(1, 0, 3, 240, 767, 5, 'h111,
          'h1DF, 'h205, 'h2EF);
      add(0, 0, 0, 0, 0, 900, 'h222,
          'h1DF, 'h205, 'h2EF);

      idle();
      tick();
      tick();
      check("rst.valid", 32'(px.out_valid), 0);
      check("rst.y", 32'(px.out_y), 0);
      check("rst.cb", 32'(px.out_cb), 'h200);
      check("rst.cr", 32'(px.out_cr), 'h200);
      check("rst.sv", 32'(stat_valid), 0);
      check("rst.sl", 32'(stat_low), 0);
      check("rst.sm", 32'(stat_mid), 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i <= tv.size(); i++) begin
         if (i < tv.size())
            drive(1, tv[i].sof, tv[i].eof, tv[i].mode,
                  tv[i].lo, tv[i].hi, tv[i].data,
                  tv[i].blue);
         else
            idle();
         tick();
         if (i >= 1)
            check_out($sformatf("tv%0d", i - 1),
                      tv[i-1].ey, tv[i-1].ecb,
                      tv[i-1].ecr);
      end
      tick();
      check("idle.valid", 32'(px.out_valid), 0);
      check("idle.y", 32'(px.out_y), 'h1DF);

      // 10-pixel frame: 3 low, 4 mid, 3 high
      pulses = 0;
      pcyc = -1;
      for (int c = 0; c < 15; c++) begin
         logic [DW-1:0] d;
         case (c)
            0: d = 10;   1: d = 300;  2: d = 50;
            3: d = 400;  4: d = 800;  5: d = 100;
            6: d = 500;  7: d = 900;  8: d = 600;
            default: d = 1000;
         endcase
         if (c < 10)
            drive(1, c == 0, c == 9, 2, 240, 767, d, 0);
         else
            idle();
         tick();
         if (stat_valid) begin
            pulses++;
            pcyc = c;
            check("frm.ovalid", 32'(px.out_valid), 1);
            check("frm.oy", 32'(px.out_y), 'h3E8);
         end
      end
      check("frm.pulses", pulses, 1);
      check("frm.cycle", pcyc, 10);
      check("frm.low", 32'(stat_low), 3);
      check("frm.mid", 32'(stat_mid), 4);

      // one-pixel frame
      drive(1, 1, 1, 2, 240, 767, 5, 0);
      tick();
      idle();
      tick();
      check("one.sv", 32'(stat_valid), 1);
      check("one.low", 32'(stat_low), 1);
      check("one.mid", 32'(stat_mid), 0);
      tick();
      check("one.sv_off", 32'(stat_valid), 0);

      // async reset between edges, mid-frame
      drive(1, 1, 0, 2, 240, 767, 100, 0);
      tick();
      drive(1, 0, 0, 2, 240, 767, 500, 0);
      tick();
      check("pre.valid", 32'(px.out_valid), 1);
      #2;
      reset = 1'b1;
      #1;
      check("ar.valid", 32'(px.out_valid), 0);
      check("ar.y", 32'(px.out_y), 0);
      check("ar.cb", 32'(px.out_cb), 'h200);
      check("ar.cr", 32'(px.out_cr), 'h200);
      check("ar.low", 32'(stat_low), 0);
      check("ar.sv", 32'(stat_valid), 0);
      idle();
      tick();
      reset = 1'b0;
      tick();

      // default config (mode 1, 240/767) until a sof
      drive(1, 0, 0, 0, 0, 0, 500, 'h0AA);
      tick();
      drive(1, 0, 1, 0, 0, 0, 100, 'h0AA);
      tick();
      check_out("dflA", 'h1F4, 'h0AA, 'h0FF);
      check("dflA.sv", 32'(stat_valid), 0);
      check("dflA.low", 32'(stat_low), 0);
      idle();
      tick();
      check_out("dflB", 'h0C9, 'h205, 'h264);
      check("dflB.sv", 32'(stat_valid), 1);
      check("dflB.low", 32'(stat_low), 1);
      check("dflB.mid", 32'(stat_mid), 1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
